// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings for the multicycle controller
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  // addi..lui (0x08-0x0F) all share this top field
  localparam logic [2:0] OP_IALU_HI = 3'b001;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;
  localparam logic [2:0] FN_SHIFT_HI = 3'b000;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_REG    = 2'b11;

  localparam logic [1:0] ALU_MEM    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_FUNC   = 2'b10;

  function automatic logic rfunc_legal(input logic [5:0] f);
    case (f)
      FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV, FN_JR,
      FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR,
      FN_NOR, FN_SLT, FN_SLTU: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - combinational classification of the latched instruction
module mc_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output logic       r_type,
  output logic       i_alu,
  output logic       lw,
  output logic       sw,
  output logic       beq,
  output logic       bne,
  output logic       j,
  output logic       jal,
  output logic       jr,
  output logic       shift,
  output logic       legal
);

  assign r_type = (op == OP_RTYPE);
  assign i_alu  = (op[5:3] == OP_IALU_HI);
  assign lw     = (op == OP_LW);
  assign sw     = (op == OP_SW);
  assign beq    = (op == OP_BEQ);
  assign bne    = (op == OP_BNE);
  assign j      = (op == OP_J);
  assign jal    = (op == OP_JAL);
  assign jr     = r_type && (func == FN_JR);
  assign shift  = r_type && (func[5:3] == FN_SHIFT_HI);

  assign legal = (r_type && rfunc_legal(func)) || i_alu || lw || sw ||
                 beq || bne || j || jal;

endmodule

// File: rtl/mc_control.sv
// rtl/mc_control.sv - multicycle MIPS-style controller with memory-wait timeout
module mc_control
  import ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
)
(
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  Opcode,
  input  logic [5:0]  Function_opcode,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        ALUSrc,
  output logic        I_format,
  output logic        Sftmd,
  output logic        Jr,
  output logic [1:0]  ALUOp,
  output logic [1:0]  PCSrc,
  output logic [2:0]  state,
  output logic        illegal,
  output logic        mem_err,
  output logic [31:0] retired
);

  localparam int CW = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_WAIT_MAX - 1);

  state_t       cur;
  logic [5:0]   op_q;
  logic [5:0]   func_q;
  logic [CW-1:0] wait_cnt;
  logic [31:0]  retired_q;

  logic d_r_type, d_i_alu, d_lw, d_sw, d_beq, d_bne, d_j, d_jal, d_jr;
  logic d_shift, d_legal;

  mc_decode u_decode (
    .op     (op_q),
    .func   (func_q),
    .r_type (d_r_type),
    .i_alu  (d_i_alu),
    .lw     (d_lw),
    .sw     (d_sw),
    .beq    (d_beq),
    .bne    (d_bne),
    .j      (d_j),
    .jal    (d_jal),
    .jr     (d_jr),
    .shift  (d_shift),
    .legal  (d_legal)
  );

  logic waiting;
  logic timeout;
  logic exec_to_fetch;

  assign waiting = (cur == S_FETCH) || (cur == S_MEM);
  // Final allowed cycle with mem_ready high is a success, so timeout needs it low
  assign timeout = waiting && !mem_ready && (wait_cnt == WAIT_LAST);
  assign exec_to_fetch = d_beq || d_bne || d_j || d_jr;

  always_ff @(posedge clock) begin
    if (reset) begin
      cur       <= S_FETCH;
      op_q      <= '0;
      func_q    <= '0;
      wait_cnt  <= '0;
      retired_q <= '0;
    end else begin
      wait_cnt <= '0;
      case (cur)
        S_FETCH: begin
          if (mem_ready) begin
            op_q   <= Opcode;
            func_q <= Function_opcode;
            cur    <= S_DECODE;
          end else if (timeout) begin
            cur <= S_FETCH;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DECODE: cur <= d_legal ? S_EXEC : S_FETCH;
        S_EXEC: begin
          if (d_lw || d_sw) begin
            cur <= S_MEM;
          end else if (exec_to_fetch) begin
            cur       <= S_FETCH;
            retired_q <= retired_q + 32'd1;
          end else begin
            cur <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            if (d_lw) begin
              cur <= S_WB;
            end else begin
              cur       <= S_FETCH;
              retired_q <= retired_q + 32'd1;
            end
          end else if (timeout) begin
            cur <= S_FETCH;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_WB: begin
          cur       <= S_FETCH;
          retired_q <= retired_q + 32'd1;
        end
        default: cur <= S_FETCH;
      endcase
    end
  end

  assign state   = cur;
  assign retired = retired_q;

  // Strobes follow state and same-cycle handshake inputs; reset masks them all
  always_comb begin
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    ALUSrc   = 1'b0;
    I_format = 1'b0;
    Sftmd    = 1'b0;
    Jr       = 1'b0;
    ALUOp    = ALU_MEM;
    PCSrc    = PC_SEQ;
    illegal  = 1'b0;
    mem_err  = 1'b0;
    if (!reset) begin
      case (cur)
        S_FETCH: begin
          MemRead = !timeout;
          mem_err = timeout;
          if (mem_ready) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            PCSrc   = PC_SEQ;
          end
        end
        S_DECODE: illegal = !d_legal;
        S_EXEC: begin
          if (d_lw || d_sw)              ALUOp = ALU_MEM;
          else if (d_beq || d_bne)       ALUOp = ALU_BRANCH;
          else if (d_r_type || d_i_alu)  ALUOp = ALU_FUNC;
          ALUSrc   = d_i_alu || d_lw || d_sw;
          I_format = d_i_alu;
          Sftmd    = d_shift;
          Jr       = d_jr;
          if (d_beq) begin
            PCWrite = Zero;
            PCSrc   = PC_BRANCH;
          end else if (d_bne) begin
            PCWrite = !Zero;
            PCSrc   = PC_BRANCH;
          end else if (d_j || d_jal) begin
            PCWrite = 1'b1;
            PCSrc   = PC_JUMP;
          end else if (d_jr) begin
            PCWrite = 1'b1;
            PCSrc   = PC_REG;
          end
        end
        S_MEM: begin
          MemRead  = d_lw && !timeout;
          MemWrite = !d_lw && !timeout;
          mem_err  = timeout;
        end
        S_WB: RegWrite = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have parameter MEM_WAIT_MAX, default 15: maximum cycles waiting on mem_ready before timeout.
REQ-002 SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port Opcode  input  6  instruction[31:26], sampled only on the IRWrite cycle.
REQ-005 SHALL have port Function_opcode  input  6  instruction[5:0], sampled with Opcode.
REQ-006 SHALL have port Zero  input  1  ALU zero flag, used in EXEC only.
REQ-007 SHALL have port mem_ready  input  1  memory handshake acknowledge.
REQ-008 SHALL have outputs PCWrite, IRWrite, MemRead, MemWrite, RegWrite, ALUSrc, I_format, Sftmd, Jr  output  1 each  datapath strobes and ALU qualifiers.
REQ-009 SHALL have outputs ALUOp  output  2 and PCSrc  output  2  ALU op class and next-PC select (00 PC+4, 01 branch, 10 jump, 11 register).
REQ-010 SHALL have outputs state  output  3, illegal  output  1, mem_err  output  1 and retired  output  32  (retired-instruction count).

Function
REQ-011 SHALL implement five states: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; encodings 5-7 go to FETCH next cycle.
REQ-012 FETCH SHALL hold MemRead=1 until mem_ready=1; that cycle it SHALL pulse IRWrite=1 and PCWrite=1 (PCSrc=00), latch Opcode/Function_opcode and enter DECODE.
REQ-013 DECODE SHALL last one cycle; unsupported opcode: illegal pulses 1 cycle, next state FETCH, retired unchanged.
REQ-014 EXEC SHALL drive ALUOp=00 for lw/sw, 01 for beq/bne, 10 for R-type and I-type ALU ops.
REQ-015 EXEC SHALL drive ALUSrc=1 for I-type ALU and lw/sw, I_format=1 iff latched op[5:3]=001, Sftmd=1 iff R-type with func[5:3]=000, and Jr=1 iff R-type with func=001000.
REQ-016 All ALU qualifiers SHALL be 0 outside EXEC.
REQ-017 EXEC transitions SHALL be:
- beq: PCWrite=Zero, PCSrc=01, then FETCH.
- bne: PCWrite=!Zero, PCSrc=01, then FETCH.
- j: PCWrite=1, PCSrc=10, then FETCH.
- jal: PCWrite=1, PCSrc=10, then WB.
- jr: PCWrite=1, PCSrc=11, then FETCH.
- lw/sw: then MEM.
- other ALU ops: then WB.
REQ-018 MEM SHALL hold MemRead (lw) or MemWrite (sw) until mem_ready=1; then lw goes to WB and sw goes to FETCH.
REQ-019 WB SHALL pulse RegWrite=1 for one cycle, then enter FETCH.
REQ-020 retired SHALL increment by 1 on every transition into FETCH from EXEC, MEM or WB, wrapping 0xFFFFFFFF->0.
REQ-021 mem_ready SHALL be ignored outside FETCH and MEM; MemRead and MemWrite SHALL never be high together.
REQ-022 When a wait in FETCH or MEM reaches MEM_WAIT_MAX cycles without mem_ready:
- mem_err pulses 1 cycle.
- All strobes drop.
- Next state is FETCH; retired unchanged.
REQ-023 The wait counter SHALL clear on every state entry; mem_ready on the final allowed cycle SHALL count as success, not timeout.

Reset
REQ-024 Reset SHALL set state=FETCH, retired=0, the latched opcode/function to 0 and the wait counter to 0.
REQ-025 Reset SHALL force all strobes, ALUOp, PCSrc, illegal and mem_err to 0, and MemRead to 0 during the reset cycle.
REQ-026 Reset asserted mid-MEM or mid-FETCH SHALL drop MemWrite/MemRead at that edge, with no write completed.

Structure
REQ-027 Opcode and function constants, state encodings and the PCSrc/ALUOp encodings SHALL live in a shared package, ctrl_pkg.
REQ-028 Combinational instruction classification SHALL be one sub-module, mc_decode (inputs: latched op/func; outputs: class flags and legality).

Verification
REQ-029 Scenario: reset, then add ($rs,$rt) with mem_ready=1 on the first FETCH cycle -> states 0,1,2,4,0; RegWrite high only in WB; ALUOp=10; retired=1.
REQ-030 Scenario: beq with Zero=1 -> PCWrite=1, PCSrc=01 in EXEC; repeat with Zero=0 -> PCWrite=0; retired=2.
REQ-031 Scenario: sw with mem_ready delayed 3 cycles -> MemWrite high exactly 4 cycles, no RegWrite, return to FETCH.
REQ-032 Scenario: lw with mem_ready held low for 15 cycles -> mem_err pulse on the 15th wait cycle, state=FETCH, retired unchanged.
REQ-033 Scenario: Opcode=0x3F -> illegal pulse in DECODE, next state FETCH; jr (func 0x08) -> Jr=1, PCSrc=11.
REQ-034 Scenario: reset asserted during MEM of sw -> MemWrite=0 after that edge, state=FETCH, retired=0.
